// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin data-memory arbiter between core LSU (A) and debug master (B) with B bus-lock and A starvation guard
module dmem_arbiter #(
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [DW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [DW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic [DW-1:0] b_rdata,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_o
);
    typedef enum logic [1:0] {IDLE_PA, IDLE_PB, LOCK_B} state_e;
    state_e        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          starve;
    always_comb begin
        starve    = a_req && (wait_q == CW'(MAX_WAIT));
        a_gnt     = a_req && (starve || (state_q != LOCK_B && (state_q == IDLE_PA || !b_req)));
        b_gnt     = b_req && !a_gnt;
        state_d   = a_gnt ? IDLE_PB
                  : b_gnt ? (b_lock ? LOCK_B : IDLE_PA)
                  : (state_q == LOCK_B ? IDLE_PA : state_q);
        wait_d    = (a_req && !a_gnt) ? (starve ? wait_q : wait_q + CW'(1)) : '0;
        mem_we    = !rst_i && ((a_gnt && a_we) || (b_gnt && b_we));
        mem_addr  = a_gnt ? a_addr : b_gnt ? b_addr : '0;
        mem_wdata = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
        a_rdata   = a_gnt ? mem_rdata : '0;
        b_rdata   = b_gnt ? mem_rdata : '0;
        stall_o   = a_req && !a_gnt;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE_PA;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end
endmodule
